// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer control FSM for a small RV32 subset (R, I-ALU, LW, SW, BEQ).
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter.
module mc_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  status,
    output logic        pcsrc,
    output logic        pc_en,
    output logic [3:0]  aluop,
    output logic [1:0]  immsel,
    output logic        alusrc,
    output logic        regrw,
    output logic        ramen,
    output logic        memrw,
    output logic        wb,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic        illegal_q;

    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_beq;
    logic is_legal;

    logic [3:0] aluop_dec;
    logic [1:0] immsel_dec;
    logic       alusrc_dec;

    logic unused_bits;

    assign is_r     = (ir[6:0] == OP_R);
    assign is_i     = (ir[6:0] == OP_I);
    assign is_ld    = (ir[6:0] == OP_LD);
    assign is_st    = (ir[6:0] == OP_ST);
    assign is_beq   = (ir[6:0] == OP_BEQ);
    assign is_legal = is_r | is_i | is_ld | is_st | is_beq;

    assign unused_bits = ^{status[3], status[1:0], ir[31], ir[29:15], ir[11:7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (state == S_FETCH && instr_valid) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && !is_legal) begin
            illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH: begin
                if (instr_valid) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nx = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_beq) begin
                    state_nx = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                state_nx = is_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_nx = S_FETCH;
            end
            S_TRAP: begin
                state_nx = S_TRAP;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

    // Operation decode from IR; only exposed on the outputs while busy.
    always_comb begin
        aluop_dec  = 4'b0000;
        immsel_dec = 2'b00;
        alusrc_dec = 1'b0;
        if (is_r || is_i) begin
            unique case (ir[14:12])
                3'b000: aluop_dec = (is_r && ir[30]) ? 4'b0001 : 4'b0000;
                3'b001: aluop_dec = 4'b0101;
                3'b010: aluop_dec = 4'b1000;
                3'b011: aluop_dec = 4'b1000;
                3'b100: aluop_dec = 4'b0100;
                3'b101: aluop_dec = ir[30] ? 4'b0111 : 4'b0110;
                3'b110: aluop_dec = 4'b0011;
                3'b111: aluop_dec = 4'b0010;
                default: aluop_dec = 4'b0000;
            endcase
        end else if (is_beq) begin
            aluop_dec = 4'b0001;
        end
        if (is_r) begin
            immsel_dec = 2'b11;
        end else if (is_st) begin
            immsel_dec = 2'b01;
        end else if (is_beq) begin
            immsel_dec = 2'b10;
        end
        alusrc_dec = is_i | is_ld | is_st;
    end

    always_comb begin
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        pc_en       = 1'b0;
        aluop       = 4'b0000;
        immsel      = 2'b00;
        alusrc      = 1'b0;
        regrw       = 1'b0;
        ramen       = 1'b0;
        memrw       = 1'b0;
        wb          = 1'b0;
        busy        = 1'b0;
        unique case (state)
            S_FETCH: begin
                instr_ready = !reset;
            end
            S_DECODE, S_EXEC, S_MEM, S_WB: begin
                busy   = 1'b1;
                aluop  = aluop_dec;
                immsel = immsel_dec;
                alusrc = alusrc_dec;
                if (state == S_EXEC && is_beq) begin
                    pcsrc = status[2];
                    pc_en = 1'b1;
                end
                if (state == S_MEM) begin
                    ramen = 1'b1;
                    memrw = is_st;
                    pc_en = is_st;
                end
                if (state == S_WB) begin
                    regrw = 1'b1;
                    wb    = is_ld;
                    pc_en = 1'b1;
                end
            end
            S_TRAP: begin
                instr_ready = 1'b0;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (pc_en) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Randomized scoreboard bench for mc_seq_ctrl with directed trap and reset cases.
module tb_mc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  status;
    logic        pcsrc;
    logic        pc_en;
    logic [3:0]  aluop;
    logic [1:0]  immsel;
    logic        alusrc;
    logic        regrw;
    logic        ramen;
    logic        memrw;
    logic        wb;
    logic        busy;
    logic        illegal;
    logic [31:0] retired_cnt;

    mc_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .status      (status),
        .pcsrc       (pcsrc),
        .pc_en       (pc_en),
        .aluop       (aluop),
        .immsel      (immsel),
        .alusrc      (alusrc),
        .regrw       (regrw),
        .ramen       (ramen),
        .memrw       (memrw),
        .wb          (wb),
        .busy        (busy),
        .illegal     (illegal),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   retired_m = 0;

    function automatic logic [15:0] obs();
        return {instr_ready, pcsrc, pc_en, aluop, immsel, alusrc,
                regrw, ramen, memrw, wb, busy, illegal};
    endfunction

    function automatic logic [15:0] vec(
        logic rdy, logic pcs, logic pce, logic [3:0] aop, logic [1:0] imm,
        logic asrc, logic rg, logic rm, logic mw, logic w, logic bsy,
        logic ill);
        return {rdy, pcs, pce, aop, imm, asrc, rg, rm, mw, w, bsy, ill};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ALU op from the funct3/funct7 rules of the ISA subset.
    function automatic logic [3:0] ref_aluop(logic [31:0] iw);
        logic [3:0] tbl [8];
        logic [2:0] f3;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
        f3 = iw[14:12];
        if (iw[6:0] == 7'b0000011 || iw[6:0] == 7'b0100011) return 4'd0;
        if (iw[6:0] == 7'b1100011) return 4'd1;
        if (f3 == 3'd0) return (iw[6:0] == 7'b0110011 && iw[30]) ? 4'd1 : 4'd0;
        if (f3 == 3'd5 && iw[30]) return 4'd7;
        return tbl[f3];
    endfunction

    task automatic issue(input logic [31:0] iw, input int zf);
        int         n;
        logic [3:0] st [5];
        logic [3:0] aop;
        logic [1:0] imm;
        logic       asrc;
        bit         c_alu, c_ld, c_st, c_beq;
        exp_t       e;
        c_alu = (iw[6:0] == 7'b0110011) || (iw[6:0] == 7'b0010011);
        c_ld  = (iw[6:0] == 7'b0000011);
        c_st  = (iw[6:0] == 7'b0100011);
        c_beq = (iw[6:0] == 7'b1100011);
        n     = c_ld ? 5 : (c_beq ? 3 : 4);
        aop   = ref_aluop(iw);
        imm   = (iw[6:0] == 7'b0110011) ? 2'b11 : c_st ? 2'b01 : c_beq ? 2'b10 : 2'b00;
        asrc  = !(c_beq || iw[6:0] == 7'b0110011);
        for (int k = 0; k < 5; k++) st[k] = 4'($urandom);
        if (zf >= 0) st[2][2] = zf[0];
        for (int k = 0; k < n; k++) begin
            e.ctl = vec(k == 0, c_beq && k == 2 && st[2][2], k == n - 1,
                        k > 0 ? aop : 4'd0, k > 0 ? imm : 2'd0,
                        k > 0 ? asrc : 1'b0,
                        (c_alu && k == 3) || (c_ld && k == 4),
                        (c_ld || c_st) && k == 3, c_st && k == 3,
                        c_ld && k == 4, k > 0, 1'b0);
            e.ret = 32'(retired_m);
            q.push_back(e);
        end
`ifdef CTRL_PERF_CNT_EN
        retired_m++;
`endif
        instr       = iw;
        instr_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            status = st[k];
            if (k > 0) begin
                instr       = $urandom;
                instr_valid = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
    endtask

    task automatic idle();
        exp_t e;
        instr_valid = 1'b0;
        instr       = $urandom;
        status      = 4'($urandom);
        e.ctl = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.ret = 32'(retired_m);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [5];
        logic [31:0] iw;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        iw = $urandom;
        iw[6:0] = ops[$urandom_range(0, 4)];
        return iw;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("ctl", obs(), e.ctl);
            check("retired", retired_cnt, e.ret);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fetch_v;
        logic [15:0] trap_v;
        fetch_v     = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        trap_v      = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        status      = '0;
        #3;
        check("reset_ctl", obs(), 16'h0);
        check("reset_ret", retired_cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_ready", obs(), fetch_v);
        @(posedge clk);
        #1;

        issue(32'h002081B3, -1);
        issue(32'h0000A183, -1);
        issue(32'h0030A023, -1);
        issue(32'h00208063, 1);
        issue(32'h00208063, 0);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue(rand_instr(), -1);
        end

        instr       = 32'h0000007F;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        check("decode_illegal", obs(), vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("trap", obs(), trap_v);
            instr  = $urandom;
            status = 4'($urandom);
        end
        reset = 1'b1;
        #1;
        check("trap_reset", obs(), 16'h0);
        check("trap_reset_ret", retired_cnt, 32'h0);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("trap_exit_ready", obs(), fetch_v);
        retired_m = 0;
        @(posedge clk);
        #1;

        instr       = 32'h0000A183;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("ld_mem", obs(), vec(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        #2;
        reset = 1'b1;
        #1;
        check("abort_ctl", obs(), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", obs(), fetch_v);
        check("abort_ret", retired_cnt, 32'h0);
        @(posedge clk);
        #1;
        check("abort_no_wb", obs(), fetch_v);

        for (int i = 0; i < 3; i++) issue(32'h002081B3, -1);
`ifdef CTRL_PERF_CNT_EN
        check("retired_three", retired_cnt, 32'd3);
`else
        check("retired_const", retired_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
